// File: rtl/datapath_pkg.sv
// Shared datapath library definitions: default operand width and word type.
package datapath_pkg;
  localparam int INC_DEFAULT_WIDTH = 4;
  typedef logic [INC_DEFAULT_WIDTH-1:0] word_t;
endpackage

// File: rtl/incrementor_4b_half_adder.sv
// Single-bit half adder; one stage of the incrementor ripple chain.
module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// File: rtl/incrementor_4b.sv
// Combinational num+1 with carry-out, plus an optional registered copy with sticky overflow.
// Registered stage is built only when INCREMENTOR_4B_REG_EN is defined; otherwise its outputs are tied to 0.
module incrementor_4b
  import datapath_pkg::*;
#(
  parameter int WIDTH = INC_DEFAULT_WIDTH
) (
  output logic [WIDTH-1:0] out,
  output logic             cout,
  input  logic [WIDTH-1:0] num,
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] out_q,
  output logic             cout_q,
  output logic             ovf_sticky
);

  logic [WIDTH:0] w_carry;

  // Carry-in fixed at 1 turns the half-adder chain into an incrementor.
  assign w_carry[0] = 1'b1;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ha
    half_adder u_ha (
      .a (num[i]),
      .b (w_carry[i]),
      .s (out[i]),
      .c (w_carry[i+1])
    );
  end

  assign cout = w_carry[WIDTH];

`ifdef INCREMENTOR_4B_REG_EN
  logic [WIDTH-1:0] r_out_q;
  logic             r_cout_q;
  logic             r_ovf_sticky;

  // Reset wins over a simultaneous carry, so the sticky flag cannot be set during reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_q      <= '0;
      r_cout_q     <= 1'b0;
      r_ovf_sticky <= 1'b0;
    end else begin
      r_out_q      <= out;
      r_cout_q     <= cout;
      r_ovf_sticky <= r_ovf_sticky | cout;
    end
  end

  assign out_q      = r_out_q;
  assign cout_q     = r_cout_q;
  assign ovf_sticky = r_ovf_sticky;
`else
  logic w_unused_clk_rst;
  assign w_unused_clk_rst = clk ^ rst;

  assign out_q      = '0;
  assign cout_q     = 1'b0;
  assign ovf_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_incrementor_4b.sv
// Directed-vector bench for incrementor_4b; registered-stage checks follow INCREMENTOR_4B_REG_EN.
module tb_incrementor_4b;
  import datapath_pkg::*;

  word_t      num;
  logic       clk;
  logic       rst;
  logic [3:0] out;
  logic       cout;
  logic [3:0] out_q;
  logic       cout_q;
  logic       ovf_sticky;

  int n_tests = 0;
  int n_fail  = 0;

  incrementor_4b #(.WIDTH(4)) dut (
    .out        (out),
    .cout       (cout),
    .num        (num),
    .clk        (clk),
    .rst        (rst),
    .out_q      (out_q),
    .cout_q     (cout_q),
    .ovf_sticky (ovf_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then move 1 ns past it before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [3:0] walk_in  [7] = '{4'b0000, 4'b0010, 4'b0100, 4'b1000, 4'b0110, 4'b1001, 4'b1011};
  logic [3:0] walk_exp [7] = '{4'b0001, 4'b0011, 4'b0101, 4'b1001, 4'b0111, 4'b1010, 4'b1100};

  initial begin
    rst = 1'b1;
    num = 4'b0000;
    #1;
    chk("reset_out", {28'd0, out}, 32'h1);
    chk("reset_cout", {31'd0, cout}, 32'h0);

    for (int i = 0; i < 7; i++) begin
      num = walk_in[i];
      #1;
      chk($sformatf("walk_out_%0d", i), {28'd0, out}, {28'd0, walk_exp[i]});
      chk($sformatf("walk_cout_%0d", i), {31'd0, cout}, 32'h0);
      #9;
    end

    num = 4'b1111;
    #1;
    chk("wrap_out", {28'd0, out}, 32'h0);
    chk("wrap_cout", {31'd0, cout}, 32'h1);
    #9;

    for (int v = 0; v < 16; v++) begin
      num = 4'(v);
      #1;
      chk($sformatf("sweep_out_%0d", v), {28'd0, out}, 32'((v + 1) % 16));
      chk($sformatf("sweep_cout_%0d", v), {31'd0, cout}, (v == 15) ? 32'h1 : 32'h0);
      #9;
    end

`ifdef INCREMENTOR_4B_REG_EN
    rst = 1'b1;
    num = 4'b0000;
    tick();
    tick();
    chk("rst_out_q", {28'd0, out_q}, 32'h0);
    chk("rst_cout_q", {31'd0, cout_q}, 32'h0);
    chk("rst_ovf", {31'd0, ovf_sticky}, 32'h0);

    rst = 1'b0;
    num = 4'b0101;
    tick();
    chk("reg_out_q", {28'd0, out_q}, 32'h6);
    chk("reg_cout_q", {31'd0, cout_q}, 32'h0);
    chk("reg_ovf_clear", {31'd0, ovf_sticky}, 32'h0);

    num = 4'b1111;
    tick();
    chk("wrap_out_q", {28'd0, out_q}, 32'h0);
    chk("wrap_cout_q", {31'd0, cout_q}, 32'h1);
    chk("wrap_ovf", {31'd0, ovf_sticky}, 32'h1);

    num = 4'b0011;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("hold_ovf_%0d", k), {31'd0, ovf_sticky}, 32'h1);
      chk($sformatf("hold_cout_q_%0d", k), {31'd0, cout_q}, 32'h0);
      chk($sformatf("hold_out_q_%0d", k), {28'd0, out_q}, 32'h4);
    end

    rst = 1'b1;
    tick();
    chk("clr_ovf", {31'd0, ovf_sticky}, 32'h0);

    num = 4'b1111;
    #1;
    chk("rstwrap_out", {28'd0, out}, 32'h0);
    chk("rstwrap_cout", {31'd0, cout}, 32'h1);
    tick();
    chk("rstwrap_ovf", {31'd0, ovf_sticky}, 32'h0);
    chk("rstwrap_out_q", {28'd0, out_q}, 32'h0);
    chk("rstwrap_cout_q", {31'd0, cout_q}, 32'h0);
    rst = 1'b0;
`else
    rst = 1'b0;
    num = 4'b1111;
    tick();
    tick();
    chk("tie_out_q", {28'd0, out_q}, 32'h0);
    chk("tie_cout_q", {31'd0, cout_q}, 32'h0);
    chk("tie_ovf", {31'd0, ovf_sticky}, 32'h0);
    num = 4'b0101;
    tick();
    chk("tie_out_q2", {28'd0, out_q}, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
